// File: rtl/switch_debounce_event_x4.sv
// ---------------------------------------------------------------------------------------------
// switch_debounce_event_x4
//   Per-channel switch front end. It synchronises the raw pins, debounces them into a stable
//   level, captures masked edges of that level as sticky events that software acknowledges,
//   and drives a registered level interrupt.
//
// Ports
//   aclk          in   1     clock; all logic uses the rising edge
//   aresetn       in   1     asynchronous active-low reset
//   sw_in         in   N_SW  raw asynchronous switch pins
//   enable_irq    in   1     global interrupt enable
//   sw_mask       in   N_SW  1 = a debounced edge on channel i is captured as an event
//   sw_event_ack  in   N_SW  single-cycle pulse per bit; clears sticky event i
//   sw_state      out  N_SW  debounced switch level
//   sw_event      out  N_SW  sticky event flags
//   irq           out  1     level interrupt (enable_irq & any event), registered
// ---------------------------------------------------------------------------------------------
module switch_debounce_event_x4 #(
   parameter int unsigned N_SW            = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [N_SW-1:0] sw_in,
   input  logic            enable_irq,
   input  logic [N_SW-1:0] sw_mask,
   input  logic [N_SW-1:0] sw_event_ack,
   output logic [N_SW-1:0] sw_state,
   output logic [N_SW-1:0] sw_event,
   output logic            irq
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      StStable,
      StSettling
   } deb_state_t;

   logic [N_SW-1:0] r_sync [SYNC_STAGES];
   logic [N_SW-1:0] w_sync_out;
   logic [N_SW-1:0] w_strobe;
   logic [N_SW-1:0] r_event;
   logic            r_irq;

   // Synchroniser chain; only the last stage is used downstream.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            r_sync[k] <= '0;
         end
      end else begin
         r_sync[0] <= sw_in;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
         end
      end
   end

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      deb_state_t      r_fsm;
      logic [CntW-1:0] r_cnt;
      logic            r_level;

      // The counter holds how many consecutive edges the synchronised input has differed from
      // the debounced level; the level flips on the edge where that run reaches DEBOUNCE_CYCLES.
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_fsm   <= StStable;
            r_cnt   <= '0;
            r_level <= 1'b0;
         end else begin
            unique case (r_fsm)
               StStable: begin
                  if (w_sync_out[i] != r_level) begin
                     r_fsm <= StSettling;
                     r_cnt <= CntW'(1);
                  end else begin
                     r_cnt <= '0;
                  end
               end
               StSettling: begin
                  if (w_sync_out[i] == r_level) begin
                     // Glitch: input returned before the run completed.
                     r_fsm <= StStable;
                     r_cnt <= '0;
                  end else if (r_cnt == CntLast) begin
                     r_level <= w_sync_out[i];
                     r_fsm   <= StStable;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CntW'(1);
                  end
               end
               default: begin
                  r_fsm <= StStable;
                  r_cnt <= '0;
               end
            endcase
         end
      end

      // Asserted in the cycle whose closing edge updates the debounced level.
      assign w_strobe[i] = (r_fsm == StSettling) && (w_sync_out[i] != r_level) &&
                           (r_cnt == CntLast);
      assign sw_state[i] = r_level;
   end

   // Set dominates acknowledge; an unmasked strobe is dropped, not deferred.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_event <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_event <= (r_event & ~sw_event_ack) | (w_strobe & sw_mask);
         r_irq   <= enable_irq & (|r_event);
      end
   end

   assign sw_event = r_event;
   assign irq      = r_irq;

endmodule
